program_memory: RTL and testbench



---
 rtl/program_memory.sv | 178 +++++++++++++++++
 tb/tb_program_memory.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory.sv
// TD4 instruction memory: registered fetch port, valid/ready program loader and,
// with PROGRAM_MEMORY_INIT_EN defined, a boot sequencer that writes the LED demo program.
module program_memory #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] order,
    output logic              busy,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_words
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1
`ifdef PROGRAM_MEMORY_INIT_EN
        , S_INIT = 2'd2
`endif
    } state_t;

`ifdef PROGRAM_MEMORY_INIT_EN
    localparam state_t     RST_STATE = S_INIT;
    localparam logic       RST_BUSY  = 1'b1;

    // Default LED program; unlisted addresses hold NOP.
    function automatic logic [DATA_W-1:0] image(input logic [ADDR_W-1:0] a);
        logic [7:0] b;
        case (a)
            ADDR_W'(0): b = 8'hb3;
            ADDR_W'(1): b = 8'hb6;
            ADDR_W'(2): b = 8'hbc;
            ADDR_W'(3): b = 8'hb8;
            ADDR_W'(4): b = 8'hb8;
            ADDR_W'(5): b = 8'hbc;
            ADDR_W'(6): b = 8'hb6;
            ADDR_W'(7): b = 8'hb3;
            ADDR_W'(8): b = 8'hb1;
            ADDR_W'(9): b = 8'h90;
            default:    b = 8'h00;
        endcase
        return DATA_W'(b);
    endfunction
`else
    localparam state_t     RST_STATE = S_IDLE;
    localparam logic       RST_BUSY  = 1'b0;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wptr, wptr_nx;
    logic              xfer, term;

    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] order_nx;
    logic              busy_nx, ready_nx, done_nx;
    logic [CNT_W-1:0]  words_nx;

    assign xfer = (state == S_LOAD) && load_valid;
    assign term = xfer && (load_last || (wptr == LAST_ADDR));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            wptr  <= '0;
        end else begin
            state <= state_nx;
            wptr  <= wptr_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        wptr_nx  = wptr;
        unique case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_nx = S_LOAD;
                    wptr_nx  = '0;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    wptr_nx = wptr + ADDR_W'(1);
                end
                if (term) begin
                    state_nx = S_IDLE;
                    wptr_nx  = '0;
                end
            end
`ifdef PROGRAM_MEMORY_INIT_EN
            S_INIT: begin
                wptr_nx = wptr + ADDR_W'(1);
                if (wptr == LAST_ADDR) begin
                    state_nx = S_IDLE;
                    wptr_nx  = '0;
                end
            end
`endif
            default: begin
                state_nx = S_IDLE;
                wptr_nx  = '0;
            end
        endcase
    end

    // Output and write-port logic; fetch is suppressed from the cycle a load is requested
    always_comb begin
        we       = 1'b0;
        wdata    = load_data;
        order_nx = '0;
        busy_nx  = (state_nx != S_IDLE);
        ready_nx = (state_nx == S_LOAD);
        done_nx  = 1'b0;
        words_nx = load_words;
        unique case (state)
            S_IDLE: begin
                if (!load_start) begin
                    order_nx = mem[address];
                end
            end
            S_LOAD: begin
                we = xfer;
                if (term) begin
                    done_nx  = 1'b1;
                    words_nx = CNT_W'(wptr) + CNT_W'(1);
                end
            end
`ifdef PROGRAM_MEMORY_INIT_EN
            S_INIT: begin
                we    = 1'b1;
                wdata = image(wptr);
            end
`endif
            default: ;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order      <= '0;
            busy       <= RST_BUSY;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            load_words <= '0;
        end else begin
            order      <= order_nx;
            busy       <= busy_nx;
            load_ready <= ready_nx;
            load_done  <= done_nx;
            load_words <= words_nx;
        end
    end

    // Storage is deliberately not reset so a loaded program survives reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: default 16x8 instance plus a 64x12 instance.
// Covers boot image (PROGRAM_MEMORY_INIT_EN builds), loads, throttling and mid-load reset.
module tb_program_memory;

`ifdef PROGRAM_MEMORY_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] addr;
    logic [7:0] order;
    logic       busy, load_start, load_valid, load_last, load_ready, load_done;
    logic [7:0] load_data;
    logic [4:0] load_words;

    logic [5:0]  addr_w;
    logic [11:0] order_w, ld_w;
    logic        busy_w, ls_w, lv_w, ll_w, lr_w, ldone_w;
    logic [6:0]  lw_w;

    program_memory u_dut (
        .clk(clk), .rst_n(rst_n), .address(addr), .order(order), .busy(busy),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .load_words(load_words)
    );

    program_memory #(.ADDR_W(6), .DATA_W(12)) u_wide (
        .clk(clk), .rst_n(rst_n), .address(addr_w), .order(order_w), .busy(busy_w),
        .load_start(ls_w), .load_valid(lv_w), .load_data(ld_w),
        .load_last(ll_w), .load_ready(lr_w), .load_done(ldone_w),
        .load_words(lw_w)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] a;
        logic [7:0] e;
    } fvec_t;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       last;
        logic       start;
    } tvec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] a, input logic [7:0] e, input string nm);
        addr = a;
        step();
        check(nm, 32'(order), 32'(e));
    endtask

    // Wait for both instances to leave boot, recording when each one fell
    task automatic wait_boot(output int nb, output int nbw);
        int cyc = 0;
        nb  = 0;
        nbw = 0;
        while (cyc < 200 && (busy || busy_w)) begin
            step();
            cyc++;
            if (!busy && nb == 0) nb = cyc;
            if (!busy_w && nbw == 0) nbw = cyc;
        end
        if (busy || busy_w) check("boot_timeout", 32'(busy | busy_w), 32'd0);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fvec_t img [11];
        fvec_t after3 [5];
        fvec_t afterthr [4];
        tvec_t thr [5];
        int nb, nbw;

        img[0] = '{4'd0, 8'hb3};  img[1] = '{4'd1, 8'hb6};  img[2]  = '{4'd2, 8'hbc};
        img[3] = '{4'd3, 8'hb8};  img[4] = '{4'd4, 8'hb8};  img[5]  = '{4'd5, 8'hbc};
        img[6] = '{4'd6, 8'hb6};  img[7] = '{4'd7, 8'hb3};  img[8]  = '{4'd8, 8'hb1};
        img[9] = '{4'd9, 8'h90};  img[10] = '{4'd15, 8'h00};
        after3[0] = '{4'd0, 8'h11}; after3[1] = '{4'd1, 8'h22}; after3[2] = '{4'd2, 8'h33};
        after3[3] = '{4'd3, 8'h43}; after3[4] = '{4'd15, 8'h4f};
        afterthr[0] = '{4'd0, 8'ha1}; afterthr[1] = '{4'd1, 8'ha3};
        afterthr[2] = '{4'd2, 8'ha5}; afterthr[3] = '{4'd3, 8'h43};
        thr[0] = '{1'b1, 8'ha1, 1'b0, 1'b0};
        thr[1] = '{1'b0, 8'hff, 1'b1, 1'b1};
        thr[2] = '{1'b1, 8'ha3, 1'b0, 1'b0};
        thr[3] = '{1'b0, 8'hfe, 1'b0, 1'b0};
        thr[4] = '{1'b1, 8'ha5, 1'b1, 1'b0};

        rst_n = 1'b0; addr = '0; load_start = 0; load_valid = 0; load_data = '0; load_last = 0;
        addr_w = '0; ls_w = 0; lv_w = 0; ld_w = '0; ll_w = 0;
        #12;
        check("rst_order", 32'(order), 32'd0);
        check("rst_busy", 32'(busy), 32'(INIT_EN));
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_words", 32'(load_words), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        if (INIT_EN) begin
            wait_boot(nb, nbw);
            check("init_len", 32'(nb), 32'd16);
            check("init_len_wide", 32'(nbw), 32'd64);
            for (int i = 0; i < 11; i++) fetch(img[i].a, img[i].e, $sformatf("img%0d", i));
        end else begin
            step();
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_busy_wide", 32'(busy_w), 32'd0);
        end

        // Full 16-word load with no last marker
        start_load();
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(load_ready), 32'd1);
        check("start_order", 32'(order), 32'd0);
        load_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            load_data = 8'(8'h40 + i);
            step();
            if (i == 14) begin
                check("full_busy15", 32'(busy), 32'd1);
                check("full_nodone15", 32'(load_done), 32'd0);
            end
        end
        check("full_done", 32'(load_done), 32'd1);
        check("full_busy", 32'(busy), 32'd0);
        check("full_ready", 32'(load_ready), 32'd0);
        check("full_words", 32'(load_words), 32'd16);
        load_data = 8'hee;
        step();
        check("extra_ready", 32'(load_ready), 32'd0);
        check("extra_done", 32'(load_done), 32'd0);
        check("extra_words", 32'(load_words), 32'd16);
        load_valid = 1'b0;
        fetch(4'd0, 8'h40, "full_m0");
        fetch(4'd15, 8'h4f, "full_m15");

        // Three-word load terminated by load_last
        start_load();
        load_valid = 1'b1;
        load_data = 8'h11; step();
        load_data = 8'h22; step();
        load_data = 8'h33; load_last = 1'b1; step();
        check("l3_done", 32'(load_done), 32'd1);
        check("l3_words", 32'(load_words), 32'd3);
        load_valid = 1'b0; load_last = 1'b0;
        step();
        check("l3_pulse", 32'(load_done), 32'd0);
        for (int i = 0; i < 5; i++) fetch(after3[i].a, after3[i].e, $sformatf("l3_f%0d", i));

        // Throttled load with a stray load_start mid-load
        start_load();
        for (int i = 0; i < 5; i++) begin
            load_valid = thr[i].v; load_data = thr[i].d;
            load_last = thr[i].last; load_start = thr[i].start;
            step();
            check($sformatf("thr_order%0d", i), 32'(order), 32'd0);
            if (i < 4) check($sformatf("thr_busy%0d", i), 32'(busy), 32'd1);
        end
        check("thr_done", 32'(load_done), 32'd1);
        check("thr_words", 32'(load_words), 32'd3);
        load_valid = 0; load_last = 0; load_start = 0;
        for (int i = 0; i < 4; i++) fetch(afterthr[i].a, afterthr[i].e, $sformatf("thr_f%0d", i));

        // Reset after two words of a five-word load
        start_load();
        load_valid = 1'b1;
        load_data = 8'hb0; step();
        load_data = 8'hb1; step();
        load_data = 8'hb2;
        check("prerst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'(INIT_EN));
        check("arst_ready", 32'(load_ready), 32'd0);
        check("arst_done", 32'(load_done), 32'd0);
        check("arst_words", 32'(load_words), 32'd0);
        check("arst_order", 32'(order), 32'd0);
        load_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        if (INIT_EN) begin
            wait_boot(nb, nbw);
            check("reinit_len", 32'(nb), 32'd16);
            fetch(4'd0, 8'hb3, "reinit_m0");
            fetch(4'd2, 8'hbc, "reinit_m2");
        end else begin
            fetch(4'd0, 8'hb0, "keep_m0");
            fetch(4'd1, 8'hb1, "keep_m1");
            fetch(4'd2, 8'ha5, "keep_m2");
        end

        // Wide instance: boot image and a full 64-word load
        if (INIT_EN) begin
            addr_w = 6'd0;  step(); check("wide_img0", 32'(order_w), 32'h0b3);
            addr_w = 6'd63; step(); check("wide_img63", 32'(order_w), 32'h000);
        end
        ls_w = 1'b1; step(); ls_w = 1'b0;
        lv_w = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ld_w = 12'(12'h100 + i);
            step();
        end
        lv_w = 1'b0;
        check("wide_done", 32'(ldone_w), 32'd1);
        check("wide_words", 32'(lw_w), 32'd64);
        check("wide_busy", 32'(busy_w), 32'd0);
        addr_w = 6'd0;  step(); check("wide_m0", 32'(order_w), 32'h100);
        addr_w = 6'd63; step(); check("wide_m63", 32'(order_w), 32'h13f);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
